// File: rtl/weight_storage_pkg.sv
// Shared types and constants for weight_storage and its write-side loader.
package weight_storage_pkg;

  localparam int INDEX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/weight_loader_if.sv
// Element stream in, storage write port out. The slave modport is the loader's view.
interface weight_loader_if
  import weight_storage_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int SIZE      = 3
);
  logic                      in_valid;
  logic [DATA_SIZE-1:0]      in_data;
  logic                      in_ready;
  logic [INDEX_WIDTH-1:0]    write_layer_index;
  logic [INDEX_WIDTH-1:0]    write_row_index;
  logic                      is_write;
  logic [DATA_SIZE*SIZE-1:0] write_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, write_layer_index, write_row_index, is_write, write_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, write_layer_index, write_row_index, is_write, write_data
  );
endinterface

// File: rtl/weight_loader_row_assembler.sv
// Packs SIZE elements MSB-first into one row word; row is the packed value
// including the element being pushed this cycle, so the caller can latch it on the full edge.
module row_assembler #(
  parameter int DATA_SIZE = 16,
  parameter int SIZE      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      push,
  input  logic [DATA_SIZE-1:0]      elem,
  output logic                      row_full,
  output logic [DATA_SIZE*SIZE-1:0] row
);
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [CW-1:0]                   cnt;
  logic [CW-1:0]                   slot;
  logic [SIZE-1:0][DATA_SIZE-1:0]  slots, slots_d;

  // First element lands in the top slice, later ones walk downward.
  assign slot     = CW'(SIZE-1) - cnt;
  assign row_full = push && (cnt == CW'(SIZE-1));
  assign row      = slots_d;

  always_comb begin
    slots_d = slots;
    if (push) slots_d[slot] = elem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      slots <= '0;
    end else if (clear) begin
      cnt   <= '0;
    end else if (push) begin
      slots <= slots_d;
      cnt   <= row_full ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/weight_loader.sv
// Streams LAYER_SIZE x SIZE rows of SIZE elements into weight_storage, one write per row.
// Optional WEIGHT_LOADER_CHECKSUM_EN builds a running element sum on checksum.
module weight_loader
  import weight_storage_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int SIZE       = 3,
  parameter int LAYER_SIZE = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  weight_loader_if.slave  bus,
  output logic            busy,
  output logic            done,
  output logic [31:0]     checksum
);
  loader_state_t             state;
  logic [INDEX_WIDTH-1:0]    layer, row;
  logic [INDEX_WIDTH-1:0]    wr_layer, wr_row;
  logic [DATA_SIZE*SIZE-1:0] wr_data;
  logic                      push, clear, row_full;
  logic [DATA_SIZE*SIZE-1:0] asm_row;

  assign bus.in_ready          = (state == COLLECT);
  assign bus.is_write          = (state == WRITE);
  assign bus.write_layer_index = wr_layer;
  assign bus.write_row_index   = wr_row;
  assign bus.write_data        = wr_data;
  assign busy                  = (state != IDLE);
  assign done                  = (state == DONE);

  assign push  = bus.in_valid && (state == COLLECT);
  assign clear = (state == IDLE) && start;

  row_assembler #(.DATA_SIZE(DATA_SIZE), .SIZE(SIZE)) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .elem     (bus.in_data),
    .row_full (row_full),
    .row      (asm_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      layer    <= '0;
      row      <= '0;
      wr_layer <= '0;
      wr_row   <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          layer <= '0;
          row   <= '0;
          state <= COLLECT;
        end
        // Write-port registers load on the edge that completes the row and hold afterwards.
        COLLECT: if (row_full) begin
          wr_data  <= asm_row;
          wr_layer <= layer;
          wr_row   <= row;
          state    <= WRITE;
        end
        WRITE: begin
          if (row == INDEX_WIDTH'(SIZE-1) && layer == INDEX_WIDTH'(LAYER_SIZE-1)) begin
            state <= DONE;
          end else begin
            if (row == INDEX_WIDTH'(SIZE-1)) begin
              row   <= '0;
              layer <= layer + INDEX_WIDTH'(1);
            end else begin
              row   <= row + INDEX_WIDTH'(1);
            end
            state <= COLLECT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sum <= '0;
    else if (clear) sum <= '0;
    else if (push)  sum <= sum + 32'(bus.in_data);
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif
endmodule
